// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Mux selects and ALU codes match the datapath's input ordering.
package mc_pkg;

  typedef enum logic [3:0] {
    StIf,
    StId,
    StMemRd,
    StLdWb,
    StMemWr,
    StJmp,
    StBrz,
    StExR,
    StExI,
    StWbAlu,
    StMovWb
  } state_e;

  typedef enum logic [3:0] {
    ClsNop,
    ClsLoad,
    ClsStore,
    ClsJump,
    ClsBrz,
    ClsMoveTo,
    ClsMoveFrom,
    ClsAluR,
    ClsAluI
  } cls_e;

  localparam logic [3:0] OpLoad  = 4'b0000;
  localparam logic [3:0] OpStore = 4'b0001;
  localparam logic [3:0] OpJump  = 4'b0010;
  localparam logic [3:0] OpBrz   = 4'b0100;
  localparam logic [3:0] OpTypeC = 4'b1000;
  localparam logic [3:0] OpAddi  = 4'b1100;
  localparam logic [3:0] OpSubi  = 4'b1101;
  localparam logic [3:0] OpAndi  = 4'b1110;
  localparam logic [3:0] OpOri   = 4'b1111;

  localparam int unsigned FnMoveTo   = 0;
  localparam int unsigned FnMoveFrom = 1;
  localparam int unsigned FnAdd      = 2;
  localparam int unsigned FnSub      = 3;
  localparam int unsigned FnAnd      = 4;
  localparam int unsigned FnOr       = 5;
  localparam int unsigned FnNot      = 6;
  localparam int unsigned FnNop      = 7;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluAnd   = 3'b010;
  localparam logic [2:0] AluOr    = 3'b011;
  localparam logic [2:0] AluNotB  = 3'b100;
  localparam logic [2:0] AluPassA = 3'b101;

  localparam logic [1:0] PcSrcImm    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcBranch = 2'd2;
  localparam logic [1:0] PcSrcAluRes = 2'd3;

  localparam logic [1:0] WrSrcA      = 2'd0;
  localparam logic [1:0] WrSrcAluOut = 2'd1;
  localparam logic [1:0] WrSrcMdr    = 2'd2;

  localparam logic [1:0] AluBReg  = 2'd0;
  localparam logic [1:0] AluBOne  = 2'd1;
  localparam logic [1:0] AluBSext = 2'd2;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of opcode/funct into an instruction class and ALU op.
module mc_decode
  import mc_pkg::*;
(
  input  logic [15:0] i_instruction,
  output cls_e        o_cls,
  output logic [2:0]  o_alu_op
);

  logic [3:0] w_opcode;
  logic [7:0] w_funct;
  logic       w_unused;

  assign w_opcode = i_instruction[15:12];
  assign w_funct  = i_instruction[7:0];
  assign w_unused = ^i_instruction[11:8];

  always_comb begin
    o_cls    = ClsNop;
    o_alu_op = AluAdd;
    case (w_opcode)
      OpLoad:  o_cls = ClsLoad;
      OpStore: o_cls = ClsStore;
      OpJump:  o_cls = ClsJump;
      OpBrz:   o_cls = ClsBrz;
      OpTypeC: begin
        // Zero or several funct bits set falls through as NOP.
        if (is_onehot8(w_funct)) begin
          unique case (1'b1)
            w_funct[FnMoveTo]:   o_cls = ClsMoveTo;
            w_funct[FnMoveFrom]: o_cls = ClsMoveFrom;
            w_funct[FnAdd]: begin
              o_cls    = ClsAluR;
              o_alu_op = AluAdd;
            end
            w_funct[FnSub]: begin
              o_cls    = ClsAluR;
              o_alu_op = AluSub;
            end
            w_funct[FnAnd]: begin
              o_cls    = ClsAluR;
              o_alu_op = AluAnd;
            end
            w_funct[FnOr]: begin
              o_cls    = ClsAluR;
              o_alu_op = AluOr;
            end
            w_funct[FnNot]: begin
              o_cls    = ClsAluR;
              o_alu_op = AluNotB;
            end
            w_funct[FnNop]: o_cls = ClsNop;
            default:        o_cls = ClsNop;
          endcase
        end
      end
      OpAddi: begin
        o_cls    = ClsAluI;
        o_alu_op = AluAdd;
      end
      OpSubi: begin
        o_cls    = ClsAluI;
        o_alu_op = AluSub;
      end
      OpAndi: begin
        o_cls    = ClsAluI;
        o_alu_op = AluAnd;
      end
      OpOri: begin
        o_cls    = ClsAluI;
        o_alu_op = AluOr;
      end
      default: o_cls = ClsNop;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control unit: state register plus combinational datapath controls.
// Outputs are forced low while reset is held so no strobe leaks during reset.
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic        zero,
  output logic [1:0]  PCSrc,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Reg1Src,
  output logic        RegDst,
  output logic [1:0]  writeSrc,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUop,
  output logic        IRWrite
);

  state_e     r_state;
  cls_e       w_cls;
  logic [2:0] w_alu_op;

  mc_decode u_decode (
    .i_instruction (instruction),
    .o_cls         (w_cls),
    .o_alu_op      (w_alu_op)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIf;
    end else begin
      case (r_state)
        StIf: r_state <= StId;
        StId: begin
          case (w_cls)
            ClsLoad:     r_state <= StMemRd;
            ClsStore:    r_state <= StMemWr;
            ClsJump:     r_state <= StJmp;
            ClsBrz:      r_state <= StBrz;
            ClsMoveTo:   r_state <= StMovWb;
            ClsMoveFrom: r_state <= StMovWb;
            ClsAluR:     r_state <= StExR;
            ClsAluI:     r_state <= StExI;
            default:     r_state <= StIf;
          endcase
        end
        StMemRd: r_state <= StLdWb;
        StExR:   r_state <= StWbAlu;
        StExI:   r_state <= StWbAlu;
        default: r_state <= StIf;
      endcase
    end
  end

  always_comb begin
    PCSrc    = PcSrcImm;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Reg1Src  = 1'b0;
    RegDst   = 1'b0;
    writeSrc = WrSrcA;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = AluBReg;
    ALUop    = AluAdd;
    IRWrite  = 1'b0;
    if (rst) begin
      case (r_state)
        StIf: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = AluBOne;
          ALUop   = AluAdd;
          PCSrc   = PcSrcAluRes;
          PCWrite = 1'b1;
        end
        StId: begin
          // PASSA on PC lets ALU_out hold PC+1 for the branch target high bits.
          ALUop   = AluPassA;
          Reg1Src = (w_cls == ClsMoveFrom);
        end
        StMemRd: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        StLdWb: begin
          writeSrc = WrSrcMdr;
          RegWrite = 1'b1;
        end
        StMemWr: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        StJmp: begin
          PCSrc   = PcSrcImm;
          PCWrite = 1'b1;
        end
        StBrz: begin
          ALUSrcA = 1'b1;
          ALUop   = AluPassA;
          PCSrc   = PcSrcBranch;
          PCWrite = zero;
        end
        StExR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = AluBReg;
          ALUop   = w_alu_op;
        end
        StExI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = AluBSext;
          ALUop   = w_alu_op;
        end
        StWbAlu: begin
          writeSrc = WrSrcAluOut;
          RegWrite = 1'b1;
        end
        StMovWb: begin
          writeSrc = WrSrcA;
          RegWrite = 1'b1;
          RegDst   = (w_cls == ClsMoveTo);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed table, reset corner cases,
// then random instructions checked against a per-cycle behavioural model.
module tb_mc_controller;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       reg1src;
    logic       regdst;
    logic [1:0] writesrc;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       irwrite;
  } ctl_t;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    int          cpi;
    ctl_t        c1;
    ctl_t        c2;
    ctl_t        c3;
    string       name;
  } vec_t;

  localparam ctl_t CZERO = '0;
  localparam ctl_t CIF   = '{pcsrc: 2'd3, pcwrite: 1'b1, memread: 1'b1, alusrcb: 2'd1,
                             irwrite: 1'b1, default: '0};
  localparam ctl_t CID   = '{aluop: 3'd5, default: '0};
  localparam ctl_t CIDMF = '{aluop: 3'd5, reg1src: 1'b1, default: '0};
  localparam ctl_t CLDM  = '{iord: 1'b1, memread: 1'b1, default: '0};
  localparam ctl_t CLDW  = '{writesrc: 2'd2, regwrite: 1'b1, default: '0};
  localparam ctl_t CST   = '{iord: 1'b1, memwrite: 1'b1, default: '0};
  localparam ctl_t CJMP  = '{pcwrite: 1'b1, default: '0};
  localparam ctl_t CBZ1  = '{alusrca: 1'b1, aluop: 3'd5, pcsrc: 2'd2, pcwrite: 1'b1,
                             default: '0};
  localparam ctl_t CBZ0  = '{alusrca: 1'b1, aluop: 3'd5, pcsrc: 2'd2, default: '0};
  localparam ctl_t CWB   = '{writesrc: 2'd1, regwrite: 1'b1, default: '0};
  localparam ctl_t CMTO  = '{regwrite: 1'b1, regdst: 1'b1, default: '0};
  localparam ctl_t CMFR  = '{regwrite: 1'b1, default: '0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instruction = '0;
  logic        zero = 1'b0;
  logic [1:0]  PCSrc, writeSrc, ALUSrcB;
  logic        PCWrite, IorD, MemRead, MemWrite, Reg1Src, RegDst, RegWrite, ALUSrcA, IRWrite;
  logic [2:0]  ALUop;
  ctl_t        act;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  mc_controller dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .zero        (zero),
    .PCSrc       (PCSrc),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Reg1Src     (Reg1Src),
    .RegDst      (RegDst),
    .writeSrc    (writeSrc),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .IRWrite     (IRWrite)
  );

  assign act = {PCSrc, PCWrite, IorD, MemRead, MemWrite, Reg1Src, RegDst, writeSrc, RegWrite,
                ALUSrcA, ALUSrcB, ALUop, IRWrite};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input ctl_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s instr=%h zero=%b got=%h required=%h", name, instruction, zero, act, exp);
    end
  endtask

  function automatic ctl_t ex(input logic [1:0] b, input logic [2:0] a);
    ctl_t c;
    c         = '0;
    c.alusrca = 1'b1;
    c.alusrcb = b;
    c.aluop   = a;
    return c;
  endfunction

  task automatic add(input logic [15:0] ins, input logic z, input int cpi, input ctl_t c1,
                     input ctl_t c2, input ctl_t c3, input string nm);
    vec_t v;
    v = '{ins, z, cpi, c1, c2, c3, nm};
    tbl.push_back(v);
  endtask

  // Reference: cycles per instruction from the instruction class.
  function automatic int model_cpi(input logic [15:0] i);
    logic [3:0] op;
    logic [7:0] f;
    op = i[15:12];
    f  = i[7:0];
    if (op == 4'd0) return 4;
    if (op == 4'd1 || op == 4'd2 || op == 4'd4) return 3;
    if (op >= 4'd12) return 4;
    if (op == 4'd8) begin
      if ($countones(f) != 1 || f[7]) return 2;
      if (f[1:0] != 2'b00) return 3;
      return 4;
    end
    return 2;
  endfunction

  // Reference: expected controls in cycle k (0 = fetch) of instruction i.
  function automatic ctl_t model_ctl(input logic [15:0] i, input logic z, input int k);
    logic [3:0] op;
    logic [7:0] f;
    int         fidx;
    ctl_t       c;
    op   = i[15:12];
    f    = i[7:0];
    fidx = 0;
    for (int b = 0; b < 8; b++) if (f[b]) fidx = b;
    if (k == 0) return CIF;
    if (k == 1) return (op == 4'd8 && f == 8'h02) ? CIDMF : CID;
    case (op)
      4'd0: return (k == 2) ? CLDM : CLDW;
      4'd1: return CST;
      4'd2: return CJMP;
      4'd4: begin
        c         = CBZ0;
        c.pcwrite = z;
        return c;
      end
      4'd8: begin
        if (f == 8'h01) return CMTO;
        if (f == 8'h02) return CMFR;
        return (k == 2) ? ex(2'd0, 3'(fidx - 2)) : CWB;
      end
      4'd12, 4'd13, 4'd14, 4'd15: return (k == 2) ? ex(2'd2, 3'(op - 4'd12)) : CWB;
      default: return CZERO;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    instruction = v.instr;
    zero        = v.z;
    for (int k = 0; k < v.cpi; k++) begin
      @(negedge clk);
      case (k)
        0:       check($sformatf("%s/if", v.name), CIF);
        1:       check($sformatf("%s/c1", v.name), v.c1);
        2:       check($sformatf("%s/c2", v.name), v.c2);
        default: check($sformatf("%s/c3", v.name), v.c3);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  ops [10];
    logic [15:0] ins;
    logic        z;
    int          cpi;
    ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};

    add(16'h0123, 1'b0, 4, CID,   CLDM, CLDW, "load");
    add(16'h1456, 1'b1, 3, CID,   CST,  CZERO, "store");
    add(16'h2ABC, 1'b0, 3, CID,   CJMP, CZERO, "jump");
    add(16'h4005, 1'b1, 3, CID,   CBZ1, CZERO, "brz_taken");
    add(16'h4005, 1'b0, 3, CID,   CBZ0, CZERO, "brz_not_taken");
    add(16'h8604, 1'b0, 4, CID,   ex(2'd0, 3'd0), CWB, "typec_add");
    add(16'h8208, 1'b1, 4, CID,   ex(2'd0, 3'd1), CWB, "typec_sub");
    add(16'h8410, 1'b0, 4, CID,   ex(2'd0, 3'd2), CWB, "typec_and");
    add(16'h8620, 1'b0, 4, CID,   ex(2'd0, 3'd3), CWB, "typec_or");
    add(16'h8E40, 1'b0, 4, CID,   ex(2'd0, 3'd4), CWB, "typec_not");
    add(16'h8A01, 1'b0, 3, CID,   CMTO, CZERO, "moveto");
    add(16'h8A02, 1'b0, 3, CIDMF, CMFR, CZERO, "movefrom");
    add(16'hC7FF, 1'b0, 4, CID,   ex(2'd2, 3'd0), CWB, "addi");
    add(16'hD00F, 1'b1, 4, CID,   ex(2'd2, 3'd1), CWB, "subi");
    add(16'hE800, 1'b0, 4, CID,   ex(2'd2, 3'd2), CWB, "andi");
    add(16'hF001, 1'b0, 4, CID,   ex(2'd2, 3'd3), CWB, "ori");
    add(16'h8006, 1'b0, 2, CID,   CZERO, CZERO, "typec_multi");
    add(16'h8000, 1'b0, 2, CID,   CZERO, CZERO, "typec_none");
    add(16'h8080, 1'b0, 2, CID,   CZERO, CZERO, "typec_nop");
    add(16'h3000, 1'b1, 2, CID,   CZERO, CZERO, "undef_op");

    // Reset held: everything low regardless of inputs.
    for (int i = 0; i < 3; i++) begin
      instruction = 16'h0123 + 16'(i);
      zero        = i[0];
      @(negedge clk);
      check("reset_hold", CZERO);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset asserted during MEM_RD aborts the load with no writeback.
    instruction = 16'h0123;
    zero        = 1'b0;
    @(negedge clk);
    check("abort/if", CIF);
    @(negedge clk);
    check("abort/id", CID);
    @(posedge clk);
    #1;
    check("abort/memrd", CLDM);
    #3;
    rst = 1'b0;
    #1;
    check("abort/async_zero", CZERO);
    @(negedge clk);
    check("abort/held_zero", CZERO);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    instruction = 16'h3000;
    @(negedge clk);
    check("abort/restart_if", CIF);
    @(negedge clk);
    check("abort/restart_id", CID);
    @(posedge clk);
    #1;

    // Random instruction stream against the reference model.
    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 4) != 0) ins[15:12] = ops[$urandom_range(0, 9)];
      if (ins[15:12] == 4'd8 && $urandom_range(0, 3) != 0)
        ins[7:0] = 8'(1 << $urandom_range(0, 7));
      z           = 1'($urandom);
      instruction = ins;
      zero        = z;
      cpi         = model_cpi(ins);
      for (int k = 0; k < cpi; k++) begin
        @(negedge clk);
        check($sformatf("rand%0d/k%0d", n, k), model_ctl(ins, z, k));
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
